// File: rtl/bug5_trig_serializer.sv
// Trigger-launched UART-style frame generator: start, WIDTH payload bits LSB first,
// optional even parity (define BUG5_PARITY_EN), stop. Payload = PATTERN + frame count.
module bug5_trig_serializer #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'hA5)
) (
  input  logic clk,
  input  logic trig,
  output logic data_o,
  input  logic rst,
  output logic busy_o
);

`ifdef BUG5_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [5:0]       idx_q, idx_d;
  logic             trig_q;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             edge_s;
  logic [WIDTH-1:0] payload_s;

`ifdef BUG5_PARITY_EN
  logic             par_q, par_d;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  assign edge_s    = trig & ~trig_q;
  assign payload_s = PATTERN + count_q;
  assign data_o    = data_q;
  assign busy_o    = busy_q;

  // Next-state and next-output logic; outputs are the registered values of data_d/busy_d.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    idx_d   = idx_q;
    data_d  = data_q;
    busy_d  = busy_q;
`ifdef BUG5_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (edge_s) begin
          state_d = S_START;
          shreg_d = payload_s;
          idx_d   = 6'd0;
          data_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef BUG5_PARITY_EN
          par_d   = even_parity(payload_s);
`endif
        end else begin
          data_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_START: begin
        state_d = S_DATA;
        data_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
        idx_d   = 6'd0;
      end
      S_DATA: begin
        // idx_q counts bits already on the line; the last one has just been shown
        if (idx_q == 6'(WIDTH - 1)) begin
`ifdef BUG5_PARITY_EN
          state_d = S_PARITY;
          data_d  = par_q;
`else
          state_d = S_STOP;
          data_d  = 1'b1;
`endif
        end else begin
          data_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 6'd1;
        end
      end
`ifdef BUG5_PARITY_EN
      S_PARITY: begin
        state_d = S_STOP;
        data_d  = 1'b1;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        data_d  = 1'b1;
        busy_d  = 1'b0;
        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
      default: begin
        state_d = S_IDLE;
        data_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      count_q <= '0;
      idx_q   <= 6'd0;
      trig_q  <= 1'b0;
      data_q  <= 1'b1;
      busy_q  <= 1'b0;
`ifdef BUG5_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      trig_q  <= trig;
      data_q  <= data_d;
      busy_q  <= busy_d;
`ifdef BUG5_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_bug5_trig_serializer.sv
// Table-driven bench for bug5_trig_serializer: two instances (PATTERN A5 and A4)
// share clk/rst/trig; each vector gives inputs and expected outputs after the posedge.
module tb_bug5_trig_serializer;

  localparam int W = 8;
`ifdef BUG5_PARITY_EN
  localparam int FLEN = W + 3;
`else
  localparam int FLEN = W + 2;
`endif

  logic clk, rst, trig;
  logic d1, b1, d2, b2;

  bug5_trig_serializer #(.WIDTH(W), .PATTERN(8'hA5)) dut1 (
    .clk(clk), .trig(trig), .data_o(d1), .rst(rst), .busy_o(b1));
  bug5_trig_serializer #(.WIDTH(W), .PATTERN(8'hA4)) dut2 (
    .clk(clk), .trig(trig), .data_o(d2), .rst(rst), .busy_o(b2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic rst;
    logic trig;
    logic d1;
    logic b1;
    logic d2;
    logic b2;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_bad;

  // Expected line level at cycle i of a frame carrying payload p.
  function automatic logic fbit(input logic [7:0] p, input int i);
    if (i == 0) return 1'b0;
    else if (i <= W) return p[i-1];
`ifdef BUG5_PARITY_EN
    else if (i == W + 1) return ^p;
`endif
    else return 1'b1;
  endfunction

  task automatic add(input logic r, input logic t, input logic e1, input logic eb1,
                     input logic e2, input logic eb2);
    vec_t v;
    v.rst = r; v.trig = t; v.d1 = e1; v.b1 = eb1; v.d2 = e2; v.b2 = eb2;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n, input logic t);
    for (int i = 0; i < n; i++) add(1'b0, t, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // First n cycles of frame number k; tp[i] is trig applied before cycle i.
  task automatic add_frame(input int k, input logic [15:0] tp, input int n);
    logic [7:0] p1, p2;
    p1 = 8'(8'hA5 + k);
    p2 = 8'(8'hA4 + k);
    for (int i = 0; i < n; i++) add(1'b0, tp[i], fbit(p1, i), 1'b1, fbit(p2, i), 1'b1);
  endtask

  task automatic chk(input string name, input int idx, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %b want %b", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] cap;
  int          nb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    trig  = 1'b0;

    // reset and quiet line
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add_idle(20, 1'b0);
    // frame 0 with trig held high through it and past it: one frame only
    add_frame(0, 16'hFFFF, FLEN);
    add_idle(3, 1'b1);
    add_idle(2, 1'b0);
    // frame 1 (A6), then back-to-back frame 2 after a single idle cycle
    add_frame(1, 16'h0001, FLEN);
    add_idle(1, 1'b0);
    add_frame(2, 16'h0001, FLEN);
    add_idle(1, 1'b0);
    // frame 3 with extra rising edges at cycles 2,4,6: ignored
    add_frame(3, 16'h0055, FLEN);
    add_idle(5, 1'b0);
    // frame 4; edge on the STOP->IDLE posedge is dropped
    add_frame(4, 16'h0001, FLEN);
    add_idle(4, 1'b1);
    add_idle(2, 1'b0);
    // frame 5 aborted by reset while data bit 3 is on the line
    add_frame(5, 16'h0001, 5);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add_idle(2, 1'b0);
    add_frame(0, 16'h0001, FLEN);
    add_idle(2, 1'b0);
    // trig held high across reset release: exactly one frame
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add_frame(0, 16'hFFFF, FLEN);
    add_idle(4, 1'b1);
    add_idle(2, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst  = vecs[i].rst;
      trig = vecs[i].trig;
      step();
      chk("data1", i, d1, vecs[i].d1);
      chk("busy1", i, b1, vecs[i].b1);
      chk("data2", i, d2, vecs[i].d2);
      chk("busy2", i, b2, vecs[i].b2);
    end

    // Hand sequence: measure busy length and capture the next frame (count 1 -> A6/A5)
    trig = 1'b1;
    step();
    nb  = 0;
    cap = 16'h0000;
    while (b1 && nb < 40) begin
      if (nb < 16) cap[nb] = d1;
      nb++;
      step();
    end
    n_cmp++;
    if (nb != FLEN) begin
      n_bad++;
      $display("FAIL busy_len: got %0d cycles want %0d", nb, FLEN);
    end
    for (int i = 0; i < FLEN; i++) chk("cap_frame", i, cap[i], fbit(8'hA6, i));
    chk("post_idle", 0, d1, 1'b1);
    trig = 1'b0;
    step();
    chk("post_idle", 1, b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
